lua_decode: RTL
===============

Name: lua_decode

Overview:
- Decode stage directly upstream of execute in the Lua 5.1 processor pipeline.
- Accepts 32-bit Lua bytecode words from fetch over a valid/ready handshake.
- Splits each word into opecode/operandA/operandB/operandC in the widths execute consumes, classifying the format (iABC/iABx/iAsBx) and flagging illegal opcodes.
- A 2-entry skid buffer gives registered backpressure with no bubble at full throughput.

Parameters:
- MAX_OPCODE, 37, highest legal Lua 5.1 opcode (VARARG); larger values are flagged illegal.
- SBX_BIAS, 131071, excess-K bias subtracted from Bx to form sBx.

Ports:
- clk_ex  in  1  pipeline clock
- n_reset  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush; discards all held instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode can accept; registered, equals "skid entry empty"
- in_instr  in  32  Lua bytecode word
- in_pc  in  32  address of in_instr
- out_valid  out  1  decoded instruction available to execute
- out_ready  in  1  execute accepts
- opecode  out  8  {2'b00, instr[5:0]}
- operandA  out  8  instr[13:6]
- operandB  out  24  B, Bx or sBx per format (see Behaviour)
- operandC  out  16  {7'b0, instr[22:14]}; 0 for iABx/iAsBx
- out_pc  out  32  pc of the presented instruction
- out_fmt  out  2  0=iABC, 1=iABx, 2=iAsBx, 3=illegal
- illegal  out  1  presented opcode > MAX_OPCODE
- decode_count  out  32  number of instructions handed to execute

Behaviour:
- Reset (n_reset low, async):
  - out_valid=0, in_ready=1, skid empty.
  - opecode, operandA, operandB, operandC, out_pc, decode_count = 0.
  - out_fmt=0, illegal=0.
  - Reset mid-transfer drops all held instructions.
- Field extraction:
  - op=instr[5:0], A=instr[13:6], C=instr[22:14], B=instr[31:23], Bx=instr[31:14].
- Format selection:
  - iABx when op in {1 LOADK, 5 GETGLOBAL, 7 SETGLOBAL, 36 CLOSURE}.
  - iAsBx when op in {22 JMP, 31 FORLOOP, 32 FORPREP}.
  - Otherwise iABC; op > MAX_OPCODE gives fmt=3 and illegal=1.
- operandB by format:
  - iABC: zero-extended 9-bit B.
  - iABx: zero-extended 18-bit Bx.
  - iAsBx: Bx - SBX_BIAS computed in signed 24-bit, range -131071..+131072, sign-extended.
  - Illegal: raw Bx. Illegal words still flow to execute, which reports them.
- RK constant bit (bit 8 of B/C) is passed through unmodified.
- Storage:
  - Output register (main) plus one skid register; decoding is done on the input side, so both hold decoded fields.
- Transfers:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - Latency: an instruction accepted in cycle N is presented in cycle N+1.
- Main/skid control:
  - Main empty, or main draining this cycle: accepted word loads main (skid first if skid full).
  - Main full, not draining, input accepted: word goes to skid; in_ready falls next cycle.
  - Skid full and main drains: skid moves to main; in_ready rises next cycle.
- Simultaneous accept+drain with skid empty: main reloads, out_valid stays 1, zero-bubble.
- Output stability: while out_valid=1 & out_ready=0, all output fields are held stable.
- Flush (sync):
  - Next cycle: out_valid=0, skid empty, in_ready=1. Any in_valid on the flush cycle is discarded.
  - decode_count is not cleared.
  - Flush has priority over simultaneous transfers; a drain on the flush cycle still counts.
- decode_count increments by 1 per output transfer and wraps 0xFFFFFFFF -> 0.
- No combinational path from out_ready to in_ready.

Test Plan:
- LOADK A=3 Bx=5 (instr=0x000140C1), out_ready=1 -> next cycle opecode=1, operandA=3, operandB=5, operandC=0, out_fmt=1, decode_count=1.
- JMP with Bx=131071 (instr=0x7FFFC016) -> operandB=0; Bx=0 (instr=0x00000016) -> operandB=0xFE0001 (-131071), out_fmt=2.
- ADD A=1 B=2 C=0x103 (instr=0x0140C04C) -> opecode=12, operandB=2, operandC=0x0103, out_fmt=0.
- opcode 0x3F -> illegal=1, out_fmt=3, instruction still presented with its pc.
- Backpressure: stream 4 words with out_ready=0 -> 2 held, in_ready=0 after 2nd accept; release out_ready -> 4 words out in order, no loss or duplication, decode_count=4.
- Flush with both entries full -> out_valid=0 next cycle, in_ready=1, following word presented normally; async reset asserted mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/lua_decode_if.sv
// Fetch-to-decode-to-execute bus for the Lua decode stage.
// The slave side is the decoder; the master side is the surrounding pipeline (fetch + execute).
interface lua_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  opecode;
    logic [7:0]  operandA;
    logic [23:0] operandB;
    logic [15:0] operandC;
    logic [31:0] out_pc;
    logic [1:0]  out_fmt;
    logic        illegal;
    logic [31:0] decode_count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, opecode, operandA, operandB, operandC,
               out_pc, out_fmt, illegal, decode_count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, opecode, operandA, operandB, operandC,
               out_pc, out_fmt, illegal, decode_count
    );
endinterface

// File: rtl/lua_decode.sv
// Lua 5.1 decode stage: splits bytecode words into execute-ready fields and
// buffers them in a main register plus one skid register (registered backpressure).
module lua_decode #(
    parameter int MAX_OPCODE = 37,
    parameter int SBX_BIAS   = 131071
) (
    input  logic         clk_ex,
    input  logic         n_reset,
    input  logic         flush,
    lua_decode_if.slave  bus
);

    localparam logic [5:0]  MAX_OP     = 6'(MAX_OPCODE);
    localparam logic [23:0] SBX_BIAS_W = 24'(SBX_BIAS);

    localparam logic [5:0] OP_LOADK     = 6'd1;
    localparam logic [5:0] OP_GETGLOBAL = 6'd5;
    localparam logic [5:0] OP_SETGLOBAL = 6'd7;
    localparam logic [5:0] OP_JMP       = 6'd22;
    localparam logic [5:0] OP_FORLOOP   = 6'd31;
    localparam logic [5:0] OP_FORPREP   = 6'd32;
    localparam logic [5:0] OP_CLOSURE   = 6'd36;

    typedef enum logic [1:0] {
        FMT_ABC  = 2'd0,
        FMT_ABX  = 2'd1,
        FMT_ASBX = 2'd2,
        FMT_ILL  = 2'd3
    } fmt_e;

    // Bit 0 = main valid, bit 1 = skid valid, so both handshake outputs come straight off flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_e;

    typedef struct packed {
        logic [7:0]  opecode;
        logic [7:0]  operand_a;
        logic [23:0] operand_b;
        logic [15:0] operand_c;
        logic [31:0] pc;
        logic [1:0]  fmt;
        logic        illegal;
    } dec_t;

    state_e      state_q, state_d;
    dec_t        main_q, main_d;
    dec_t        skid_q, skid_d;
    logic [31:0] count_q, count_d;

    dec_t        dec;
    logic [5:0]  op;
    logic [17:0] bx;
    logic [1:0]  state_bits;
    logic        in_xfer;
    logic        out_xfer;

    assign state_bits = state_q;
    assign in_xfer    = bus.in_valid & ~state_bits[1];
    assign out_xfer   = state_bits[0] & bus.out_ready;

    // Decode on the input side so both storage slots hold finished fields.
    always_comb begin
        op  = bus.in_instr[5:0];
        bx  = bus.in_instr[31:14];
        dec = '0;
        dec.opecode   = {2'b00, op};
        dec.operand_a = bus.in_instr[13:6];
        dec.operand_b = {15'b0, bus.in_instr[31:23]};
        dec.operand_c = {7'b0, bus.in_instr[22:14]};
        dec.pc        = bus.in_pc;
        dec.fmt       = FMT_ABC;
        dec.illegal   = 1'b0;
        if (op > MAX_OP) begin
            dec.fmt       = FMT_ILL;
            dec.illegal   = 1'b1;
            dec.operand_b = {6'b0, bx};
        end else begin
            case (op)
                OP_LOADK, OP_GETGLOBAL, OP_SETGLOBAL, OP_CLOSURE: begin
                    dec.fmt       = FMT_ABX;
                    dec.operand_b = {6'b0, bx};
                    dec.operand_c = '0;
                end
                OP_JMP, OP_FORLOOP, OP_FORPREP: begin
                    // Two's-complement wrap yields the sign-extended excess-K value.
                    dec.fmt       = FMT_ASBX;
                    dec.operand_b = {6'b0, bx} - SBX_BIAS_W;
                    dec.operand_c = '0;
                end
                default: dec.fmt = FMT_ABC;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q + {31'b0, out_xfer};
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_xfer) begin
                        if (in_xfer) main_d = dec;
                        else         state_d = ST_EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_ex or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign bus.out_valid    = state_bits[0];
    assign bus.in_ready     = ~state_bits[1];
    assign bus.opecode      = main_q.opecode;
    assign bus.operandA     = main_q.operand_a;
    assign bus.operandB     = main_q.operand_b;
    assign bus.operandC     = main_q.operand_c;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_fmt      = main_q.fmt;
    assign bus.illegal      = main_q.illegal;
    assign bus.decode_count = count_q;

endmodule
